// File: rtl/vault_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vault_pkg
//  Description : Shared definitions for the vault alarm controller: state
//                encodings, parameter defaults and a small sizing helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package vault_pkg;

    // Parameter defaults
    localparam int DEF_MAX_TRIES      = 3;
    localparam int DEF_ALARM_CYCLES   = 16;
    localparam int DEF_LOCKOUT_CYCLES = 64;
    localparam int DEF_UNLOCK_CYCLES  = 8;

    // Controller state encodings; 5..7 are unreachable and recover to IDLE
    localparam int         c_STATE_W    = 3;
    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_RETRY   = 3'd1;
    localparam logic [2:0] c_ST_ALARM   = 3'd2;
    localparam logic [2:0] c_ST_LOCKOUT = 3'd3;
    localparam logic [2:0] c_ST_OPEN    = 3'd4;

    // Largest of three durations, used to size the shared timer
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vault_timer.sv
`default_nettype none
// ============================================================================
//  Module      : vault_timer
//  Description : Loadable down-counter shared by the timed controller states.
//                'expired' is high during the last cycle of a loaded interval,
//                so a load value of N yields exactly N cycles in a state.
//  Ports       : clk, reset_n      - clock, async active-low reset
//                load, load_value  - reload strobe and value
//                expired           - final cycle of the interval
//  Revision    : 1.0 - initial release
// ============================================================================
module vault_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;

    // Stops at zero so untimed states simply hold 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign expired = (r_count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/vault_alarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vault_alarm_ctrl
//  Description : Moore supervisor around a phase FSM. Counts phase failures,
//                raises an alarm and lockout after MAX_TRIES failures, and
//                releases the vault door after a successful phase.
//  Ports       : clk, reset_n             - clock, async active-low reset
//                phase_done, phase_fail   - status levels from the phase FSM
//                clear_alarm              - operator acknowledge
//                phase_rst                - reset to the phase FSM
//                unlock, alarm, locked_out- registered state outputs
//                fail_count               - failures since success/lockout
//  Revision    : 1.0 - initial release
// ============================================================================
module vault_alarm_ctrl
    import vault_pkg::*;
#(
    parameter int MAX_TRIES      = DEF_MAX_TRIES,
    parameter int ALARM_CYCLES   = DEF_ALARM_CYCLES,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       phase_done,
    input  logic       phase_fail,
    input  logic       clear_alarm,
    output logic       phase_rst,
    output logic       unlock,
    output logic       alarm,
    output logic       locked_out,
    output logic [3:0] fail_count
);

    localparam int c_CNT_W =
        $clog2(max3(ALARM_CYCLES, LOCKOUT_CYCLES, UNLOCK_CYCLES) + 1);

    localparam logic [c_CNT_W-1:0] c_ALARM_LD   = c_CNT_W'(ALARM_CYCLES);
    localparam logic [c_CNT_W-1:0] c_LOCKOUT_LD = c_CNT_W'(LOCKOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_UNLOCK_LD  = c_CNT_W'(UNLOCK_CYCLES);
    localparam logic [3:0]         c_MAX_TRIES  = 4'(MAX_TRIES);

    logic [c_STATE_W-1:0] r_state;
    logic [3:0]           r_fail_count;
    logic                 r_phase_rst;
    logic                 r_unlock;
    logic                 r_alarm;
    logic                 r_locked_out;

    logic [c_STATE_W-1:0] w_next_state;
    logic [3:0]           w_next_fail;
    logic                 w_load;
    logic [c_CNT_W-1:0]   w_load_value;
    logic                 w_expired;

    vault_timer #(
        .WIDTH (c_CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (w_load),
        .load_value (w_load_value),
        .expired    (w_expired)
    );

    // Next-state and next-count decode
    always_comb begin
        w_next_state = c_ST_IDLE;
        w_next_fail  = r_fail_count;
        case (r_state)
            c_ST_IDLE: begin
                // A success wins over a simultaneous failure
                if (phase_done) begin
                    w_next_state = c_ST_OPEN;
                    w_next_fail  = 4'd0;
                end else if (phase_fail) begin
                    if (r_fail_count >= c_MAX_TRIES) begin
                        // Saturate rather than wrap on a corrupted count
                        w_next_state = c_ST_ALARM;
                    end else begin
                        w_next_fail  = r_fail_count + 4'd1;
                        w_next_state = (w_next_fail == c_MAX_TRIES) ? c_ST_ALARM
                                                                    : c_ST_RETRY;
                    end
                end else begin
                    w_next_state = c_ST_IDLE;
                end
            end
            c_ST_RETRY: begin
                w_next_state = c_ST_IDLE;
            end
            c_ST_ALARM: begin
                w_next_state = (clear_alarm || w_expired) ? c_ST_LOCKOUT : c_ST_ALARM;
            end
            c_ST_LOCKOUT: begin
                if (w_expired) begin
                    w_next_state = c_ST_IDLE;
                    w_next_fail  = 4'd0;
                end else begin
                    w_next_state = c_ST_LOCKOUT;
                end
            end
            c_ST_OPEN: begin
                w_next_state = w_expired ? c_ST_RETRY : c_ST_OPEN;
            end
            default: begin
                w_next_state = c_ST_IDLE;
                w_next_fail  = 4'd0;
            end
        endcase
    end

    // Timer reloads on every state change; untimed states load 0
    always_comb begin
        w_load       = (w_next_state != r_state);
        w_load_value = '0;
        case (w_next_state)
            c_ST_ALARM:   w_load_value = c_ALARM_LD;
            c_ST_LOCKOUT: w_load_value = c_LOCKOUT_LD;
            c_ST_OPEN:    w_load_value = c_UNLOCK_LD;
            default:      w_load_value = '0;
        endcase
    end

    // State plus registered Moore outputs decoded from the state being entered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_ST_IDLE;
            r_fail_count <= 4'd0;
            r_phase_rst  <= 1'b0;
            r_unlock     <= 1'b0;
            r_alarm      <= 1'b0;
            r_locked_out <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_fail_count <= w_next_fail;
            r_phase_rst  <= (w_next_state == c_ST_RETRY) ||
                            (w_next_state == c_ST_ALARM) ||
                            (w_next_state == c_ST_LOCKOUT);
            r_unlock     <= (w_next_state == c_ST_OPEN);
            r_alarm      <= (w_next_state == c_ST_ALARM);
            r_locked_out <= (w_next_state == c_ST_LOCKOUT);
        end
    end

    assign phase_rst  = r_phase_rst;
    assign unlock     = r_unlock;
    assign alarm      = r_alarm;
    assign locked_out = r_locked_out;
    assign fail_count = r_fail_count;

endmodule
`default_nettype wire

// File: doc/vault_alarm_ctrl.md
VAULT_ALARM_CTRL -- requirements
Module: vault_alarm_ctrl

Interface
REQ-001 Parameter MAX_TRIES, default 3, number of phase failures that trigger the alarm (range 1..15).
REQ-002 Parameter ALARM_CYCLES, default 16, clock cycles alarm stays asserted.
REQ-003 Parameter LOCKOUT_CYCLES, default 64, clock cycles of lockout after the alarm.
REQ-004 Parameter UNLOCK_CYCLES, default 8, clock cycles unlock stays asserted.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 phase_done  input  1  level from the phase FSM, high while that FSM sits in DONE.
REQ-008 phase_fail  input  1  level from the phase FSM, high while that FSM sits in FAIL.
REQ-009 clear_alarm  input  1  operator acknowledge; high for one or more cycles.
REQ-010 phase_rst  output  1  active-high reset driven to the phase FSM.
REQ-011 unlock  output  1  vault door release.
REQ-012 alarm  output  1  audible/visual alarm drive.
REQ-013 locked_out  output  1  high while new attempts are refused.
REQ-014 fail_count  output  4  number of failures since the last success or lockout expiry.

Function
REQ-015 The block SHALL be a Moore FSM with states IDLE, RETRY, ALARM, LOCKOUT, OPEN; all outputs are registered and decoded from the current state and fail_count only.
REQ-016 IDLE: all outputs 0 except fail_count; phase_done sampled high -> OPEN with fail_count cleared to 0; else phase_fail high -> fail_count+1, then ALARM if the new count equals MAX_TRIES, else RETRY.
REQ-017 phase_done and phase_fail high in the same IDLE cycle SHALL be treated as phase_done only.
REQ-018 RETRY: phase_rst=1 for exactly one cycle, inputs ignored, unconditional -> IDLE.
REQ-019 ALARM: alarm=1 and phase_rst=1; down-counter loaded with ALARM_CYCLES on entry; -> LOCKOUT after ALARM_CYCLES cycles, or on the cycle after clear_alarm is sampled high, whichever comes first.
REQ-020 LOCKOUT: locked_out=1 and phase_rst=1 for exactly LOCKOUT_CYCLES cycles; phase_done/phase_fail/clear_alarm ignored; on exit fail_count cleared to 0 -> IDLE.
REQ-021 OPEN: unlock=1 for exactly UNLOCK_CYCLES cycles; inputs ignored; -> RETRY on expiry so the phase FSM is restarted.
REQ-022 Latency: an input sampled at edge N SHALL be reflected on outputs after edge N, i.e. visible in cycle N+1.
REQ-023 fail_count SHALL never exceed MAX_TRIES and never wrap.
REQ-024 A single shared down-counter SHALL time ALARM, LOCKOUT and OPEN; it is reloaded on every state entry and holds 0 in IDLE and RETRY.
REQ-025 clear_alarm outside ALARM SHALL have no effect.
REQ-026 Unreachable state encodings SHALL transition to IDLE on the next edge.

Reset
REQ-027 reset_n low SHALL immediately force state IDLE, counter 0, fail_count 0, and phase_rst, unlock, alarm, locked_out to 0, regardless of the current state.
REQ-028 After reset_n deasserts, the first active edge SHALL evaluate IDLE transitions normally.

Structure
REQ-029 State encodings and parameter defaults SHALL live in shared package vault_pkg.
REQ-030 The cycle timer SHALL be one sub-module, vault_timer: load value, load strobe, expiry flag.

Verification
REQ-031 reset_n low during ALARM cycle 5 -> alarm, phase_rst and fail_count read 0 before the next clock edge.
REQ-032 phase_fail high at edge 0 from IDLE -> fail_count=1, phase_rst high in cycle 1 only, IDLE in cycle 2.
REQ-033 three separate failures -> alarm high for 16 cycles, then locked_out high for 64 cycles, phase_rst high for all 80 cycles, then IDLE with fail_count=0.
REQ-034 two failures then phase_done -> fail_count=0, unlock high for 8 cycles, then one phase_rst cycle, then IDLE.
REQ-035 phase_done and phase_fail both high in IDLE -> OPEN, fail_count unchanged at 0, alarm stays 0.
REQ-036 clear_alarm high in ALARM cycle 5 -> alarm 0 from cycle 6, locked_out high for 64 cycles.
